// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating multiplexer.
package rr_mux_pkg;

  localparam int CNT_W = 16;

  // Successor of idx in a ring of n slots.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-scan picker: the first request at or after ptr wins,
// wrapping past N_IN-1 back to 0.
module rr_pick #(
  parameter int N_IN = 4,
  parameter int SW   = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_IN-1:0] gnt,
  output logic [SW-1:0]   idx,
  output logic            any
);

  // NOTE: every output gets a default before the scan so no latch is inferred.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N_IN) c = c - N_IN;
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = SW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbitrating mux with a single registered valid/ready output.
// Optional accepted-transfer counter enabled by defining RR_MUX_STATS_EN.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 8,
  parameter int SW   = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_valid,
  input  logic [W-1:0]     in_data [N_IN],
  output logic [N_IN-1:0]  in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_src,
  input  logic             out_ready
`ifdef RR_MUX_STATS_EN
  , output logic [CNT_W-1:0] grant_cnt
`endif
);

  logic [SW-1:0]   ptr;
  logic [N_IN-1:0] win_gnt;
  logic [SW-1:0]   win_idx;
  logic            win_any;
  logic            free;
  logic            grant;

  rr_pick #(.N_IN(N_IN), .SW(SW)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // The register can take a new item when empty or when it drains this cycle.
  assign free     = !out_valid || out_ready;
  assign grant    = free && win_any;
  assign in_ready = free ? win_gnt : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= in_data[win_idx];
      out_src   <= win_idx;
      ptr       <= SW'(next_idx(int'(win_idx), N_IN));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_STATS_EN
  // Saturating count of completed output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (out_valid && out_ready && (grant_cnt != '1)) begin
      grant_cnt <= grant_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (N_IN=4, W=8); stats checks
// run when RR_MUX_STATS_EN is defined.
module tb_rr_mux_arbiter;

  localparam int N_IN = 4;
  localparam int W    = 8;
  localparam int SW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_IN-1:0] in_valid = '0;
  logic [W-1:0]    in_data [N_IN];
  logic [N_IN-1:0] in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready = 1'b0;
`ifdef RR_MUX_STATS_EN
  logic [15:0]     grant_cnt;
`endif

  int checks = 0;
  int failures = 0;

  rr_mux_arbiter #(.N_IN(N_IN), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef RR_MUX_STATS_EN
    , .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) in_data[i] = 8'h10 + 8'(i);

    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_src", 32'(out_src), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_valid", 32'(out_valid), 0);

    // Single source 2
    in_valid = 4'b0100;
    in_data[2] = 8'hA5;
    out_ready = 1'b1;
    settle();
    check("single_in_ready", 32'(in_ready), 32'b0100);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_src", 32'(out_src), 2);

    // Asynchronous reset while holding an item (ptr is now 3)
    in_valid = '0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_src", 32'(out_src), 0);
    tick();
    rst_n = 1'b1;
    in_data[2] = 8'h12;

    // Full rotation from ptr=0
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      settle();
      check($sformatf("rot_in_ready%0d", n), 32'(in_ready), 32'(1) << (n % 4));
      tick();
      check($sformatf("rot_valid%0d", n), 32'(out_valid), 1);
      check($sformatf("rot_src%0d", n), 32'(out_src), 32'(n % 4));
      check($sformatf("rot_data%0d", n), 32'(out_data), 32'h10 + 32'(n % 4));
    end

    // Grant source 1 (ptr=2, scan 2,3,0,1), then stall five cycles
    in_valid = 4'b0010;
    tick();
    check("bp_grant_src", 32'(out_src), 1);
    out_ready = 1'b0;
    in_valid = 4'b1011;
    in_data[1] = 8'hEE;
    for (int n = 0; n < 5; n++) begin
      settle();
      check($sformatf("bp_in_ready%0d", n), 32'(in_ready), 0);
      tick();
      check($sformatf("bp_valid%0d", n), 32'(out_valid), 1);
      check($sformatf("bp_src%0d", n), 32'(out_src), 1);
      check($sformatf("bp_data%0d", n), 32'(out_data), 32'h11);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_in_ready", 32'(in_ready), 32'b1000);
    tick();
    check("bp_release_src", 32'(out_src), 3);
    check("bp_release_data", 32'(out_data), 32'h13);

    // Move ptr to 3 via source 2, then wrap and skip with 0110
    in_valid = 4'b0100;
    tick();
    check("ws_setup_src", 32'(out_src), 2);
    in_valid = 4'b0110;
    settle();
    check("ws_in_ready1", 32'(in_ready), 32'b0010);
    tick();
    check("ws_src1", 32'(out_src), 1);
    settle();
    check("ws_in_ready2", 32'(in_ready), 32'b0100);
    tick();
    check("ws_src2", 32'(out_src), 2);

    // Drain to EMPTY; idle cycles must not move ptr (still 3)
    in_valid = '0;
    tick();
    check("drain_valid", 32'(out_valid), 0);
    tick();
    tick();
    in_valid = 4'b1111;
    settle();
    check("idle_keep_ptr", 32'(in_ready), 32'b1000);
    tick();
    check("idle_keep_src", 32'(out_src), 3);
    in_valid = '0;
    tick();

`ifdef RR_MUX_STATS_EN
    // Fresh counter: 10 handshakes
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("cnt_rst", 32'(grant_cnt), 0);
    in_valid = 4'b0001;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    in_valid = '0;
    tick();
    check("cnt_ten", 32'(grant_cnt), 10);
    check("cnt_ten_empty", 32'(out_valid), 0);

    // Long run past saturation
    in_valid = 4'b0011;
    for (int n = 0; n < 65540; n++) tick();
    in_valid = '0;
    tick();
    check("cnt_sat", 32'(grant_cnt), 32'hFFFF);
    in_valid = 4'b0001;
    for (int n = 0; n < 4; n++) tick();
    check("cnt_sat_hold", 32'(grant_cnt), 32'hFFFF);
    in_valid = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin N:1 arbitrating multiplexer with a registered valid/ready output. It sits directly upstream of the combinational mux/gate stages. It decides which of N_IN sources wins each cycle, then presents the winner's data and index (the select value) from a single output register. It turns the purely combinational select into a flow-controlled, fair, one-cycle-latency stage.

## Interface
- N_IN, default 4: number of sources; legal range 2..16; need not be a power of two.
- W, default 8: data width per source.
- SW, derived $clog2(N_IN): width of the source index.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears state immediately; release is synchronised externally.
- in_valid  input  N_IN  per-source request.
- in_data  input  N_IN x W  per-source data, unpacked array indexed by source.
- in_ready  output  N_IN  per-source accept, one-hot or zero.
- out_valid  output  1  output register holds a transfer.
- out_data  output  W  registered winning data.
- out_src  output  SW  registered index of the winning source (mux select).
- out_ready  input  1  downstream accept.
- grant_cnt  output  16  accepted-transfer count; present only with RR_MUX_STATS_EN.

## Operation
- Internal state: output register (out_valid, out_data, out_src) and a round-robin pointer ptr[SW].
- Two states, encoded by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- free = !out_valid || out_ready. Taking a new item while out_ready is high in FULL is allowed, so throughput is 1 per cycle.
- Pick rule: when free, the winner is the first i with in_valid[i]=1, scanning ptr, ptr+1, … N_IN-1, 0, … ptr-1.
- in_ready[winner]=1 combinationally. All other in_ready bits are 0. All in_ready bits are 0 when !free or no in_valid.
- On a clock edge with a grant:
  - out_data <= in_data[winner]
  - out_src <= winner
  - out_valid <= 1
  - ptr <= winner+1, wrapping from N_IN-1 to 0.
- EMPTY → FULL on a grant. EMPTY stays EMPTY with no requests.
- FULL → EMPTY when out_ready=1 and there is no grant.
- FULL stays FULL when out_ready=0 (hold) or when out_ready=1 with a grant (replace).
- While FULL and out_ready=0: out_data and out_src are stable, no in_ready is asserted, and ptr is unchanged.
- ptr changes only on a grant. Idle cycles do not advance it.
- A source that drops in_valid without a grant loses nothing; no state is recorded for it.
- An out-of-range ptr cannot occur. Out-of-range select indices are never generated.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, grant_cnt=0, in_ready=0 (in_ready forced only by out_valid=0 and no requests).
- Latency from in_valid&in_ready to out_valid is 1 cycle.
- Combinational paths:
  - in_valid → in_ready.
  - out_ready → in_ready.
  - No path from in_data to any output except through the register.
- Reset asserted mid-transfer: the held item is dropped, out_valid goes 0 asynchronously, and ptr returns to 0.
- Fairness: with all sources continuously valid and out_ready=1, each source is granted exactly once every N_IN cycles.

## Configuration
- RR_MUX_STATS_EN defined:
  - Adds output grant_cnt[15:0].
  - It increments on every cycle with out_valid && out_ready.
  - It saturates at 16'hFFFF and never wraps.
  - Reset value is 0.
- Undefined: no grant_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Package rr_mux_pkg holds:
  - CNT_W = 16.
  - A function next_idx(idx, n) that returns idx+1 with wrap at n.
- Sub-module rr_pick: combinational. Inputs are the request vector and ptr. Outputs are a one-hot grant and the encoded index. It holds the rotate-and-priority-scan logic.
- The top holds the output register, ptr, free logic and the optional counter.

## Test plan
- Reset check: assert rst_n=0 mid-cycle with out_valid=1 → out_valid=0 at once; after release, out_src=0 and ptr=0.
- Single source: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1.
  - Response: in_ready=4'b0100.
  - Next cycle: out_valid=1, out_data=8'hA5, out_src=2.
- Full rotation: in_valid=4'b1111 held, out_ready=1, N_IN=4 → out_src sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 throughout.
- Backpressure: out_ready=0 for 5 cycles after a grant of source 1.
  - During the stall: in_ready=0, and out_data/out_src are unchanged.
  - On release with in_valid=4'b1011: the next grant is source 3.
- Wrap and skip: ptr=3 with in_valid=4'b0110 → grant source 1, then source 2.
- With RR_MUX_STATS_EN:
  - 10 handshakes → grant_cnt=10.
  - Preload-style run of 65 540 handshakes → grant_cnt=16'hFFFF.
